// File: rtl/receptor_sumador.sv
// receptor_sumador: receiving end of the pipelined 4-bit adder stream.
// Buffers (idx, sum) beats in a first-word-fall-through FIFO and hands them
// downstream with a valid/ready handshake. Drops beats when full, with a
// sticky overflow flag.
// Optional feature macro: SEQ_CHECK_EN. When it is defined, an IDLE/TRACK/ERROR
// FSM checks that the idx tags increment by one modulo 16 and records the
// first out-of-sequence tag. When it is undefined, seq_err and err_idx are
// tied to 0.
module receptor_sumador #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [3:0]               idx_dd,
  input  logic [WIDTH-1:0]         sum30_dd,
  input  logic                     ready_in,
  output logic                     valid_out,
  output logic [3:0]               idx_out,
  output logic [WIDTH-1:0]         sum_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     seq_err,
  output logic [3:0]               err_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]       r_mem_idx [DEPTH];
  logic [WIDTH-1:0] r_mem_sum [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_overflow;

  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CW-1:0]    w_count_nxt;

  // A pop needs a valid head; a push into a full FIFO is only legal when the
  // head leaves on the same edge, so occupancy then stays at DEPTH.
  assign w_empty = (r_count == {CW{1'b0}});
  assign w_pop   = (!w_empty) && ready_in;
  assign w_push  = valid_in && ((!r_full) || w_pop);
  assign w_drop  = valid_in && r_full && (!w_pop);

  // Next occupancy from the push/pop pair of this cycle.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array write at the write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_idx[i] <= 4'd0;
        r_mem_sum[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push) begin
      r_mem_idx[r_wptr] <= idx_dd;
      r_mem_sum[r_wptr] <= sum30_dd;
    end
  end

  // Pointers, occupancy, full and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head of the FIFO falls through from registered storage; masked when empty.
  assign valid_out = !w_empty;
  assign idx_out   = w_empty ? 4'd0 : r_mem_idx[r_rptr];
  assign sum_out   = w_empty ? {WIDTH{1'b0}} : r_mem_sum[r_rptr];
  assign count     = r_count;
  assign full      = r_full;
  assign overflow  = r_overflow;

`ifdef SEQ_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ERROR = 2'd2
  } seq_state_t;

  seq_state_t r_state;
  logic [3:0] r_exp;
  logic       r_seq_err;
  logic [3:0] r_err_idx;

  // Sequence checker: every input beat, dropped or not, is compared against
  // the expected tag; the first mismatch is latched and the FSM parks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_exp     <= 4'd0;
      r_seq_err <= 1'b0;
      r_err_idx <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_exp   <= idx_dd + 4'd1;
            r_state <= S_TRACK;
          end
        end
        S_TRACK: begin
          if (valid_in) begin
            r_exp <= idx_dd + 4'd1;
            if (idx_dd != r_exp) begin
              r_seq_err <= 1'b1;
              r_err_idx <= idx_dd;
              r_state   <= S_ERROR;
            end
          end
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign seq_err = r_seq_err;
  assign err_idx = r_err_idx;
`else
  assign seq_err = 1'b0;
  assign err_idx = 4'd0;
`endif

endmodule

// File: tb/tb_receptor_sumador.sv
// Self-checking bench for receptor_sumador (DEPTH=4, WIDTH=4). A queue-based
// FIFO model and a simple tag-tracking model predict every output each cycle;
// directed steps follow the test plan, then a randomized phase runs.
// Expectations for the sequence checker follow the SEQ_CHECK_EN macro.
module tb_receptor_sumador;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [3:0] idx_dd = 4'd0;
  logic [3:0] sum30_dd = 4'd0;
  logic       ready_in = 1'b0;
  logic       valid_out;
  logic [3:0] idx_out;
  logic [3:0] sum_out;
  logic [2:0] count;
  logic       full;
  logic       overflow;
  logic       seq_err;
  logic [3:0] err_idx;

  int checks = 0;
  int failures = 0;

  // model state
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_started = 1'b0;
  logic [3:0] m_exp = 4'd0;
  logic       m_err = 1'b0;
  logic [3:0] m_err_idx = 4'd0;

  receptor_sumador #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .idx_dd(idx_dd),
    .sum30_dd(sum30_dd), .ready_in(ready_in), .valid_out(valid_out),
    .idx_out(idx_out), .sum_out(sum_out), .count(count), .full(full),
    .overflow(overflow), .seq_err(seq_err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'd0;
    check_eq("valid_out", 32'(valid_out), 32'(q.size() != 0));
    check_eq("idx_out",   32'(idx_out),   32'(head[7:4]));
    check_eq("sum_out",   32'(sum_out),   32'(head[3:0]));
    check_eq("count",     32'(count),     32'(q.size()));
    check_eq("full",      32'(full),      32'(q.size() == DEPTH));
    check_eq("overflow",  32'(overflow),  32'(m_ovf));
    check_eq("seq_err",   32'(seq_err),   32'(m_err));
    check_eq("err_idx",   32'(err_idx),   32'(m_err_idx));
  endtask

  task automatic clear_model();
    q.delete();
    m_ovf = 1'b0;
    m_started = 1'b0;
    m_exp = 4'd0;
    m_err = 1'b0;
    m_err_idx = 4'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    @(posedge clk);
    clear_model();
    #1;
    reset = 1'b0;
    check_all();
  endtask

  // one clock cycle of stimulus, model update and full output comparison
  task automatic step(input logic v, input logic [3:0] idx, input logic [3:0] sm, input logic rdy);
    logic pop_ok;
    logic full_m;
    valid_in = v;
    idx_dd = idx;
    sum30_dd = sm;
    ready_in = rdy;
    @(posedge clk);
    full_m = (q.size() == DEPTH);
    pop_ok = (q.size() != 0) && rdy;
    if (pop_ok) q.delete(0);
    if (v) begin
      if (!full_m || pop_ok) q.push_back({idx, sm});
      else m_ovf = 1'b1;
    end
`ifdef SEQ_CHECK_EN
    if (v && !m_err) begin
      if (m_started && idx != m_exp) begin
        m_err = 1'b1;
        m_err_idx = idx;
      end
      m_started = 1'b1;
      m_exp = idx + 4'd1;
    end
`endif
    #1;
    check_all();
  endtask

  task automatic drain();
    step(1'b0, 4'd0, 4'd0, 1'b1);
  endtask

  initial begin
    logic [3:0] last;
    logic [3:0] nidx;

    // reset state
    do_reset();
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);

    // streaming with ready held high
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 4'(k), 4'(k + 3), 1'b1);
      check_eq("t1_idx", 32'(idx_out), 32'(k));
      check_eq("t1_sum", 32'(sum_out), 32'(k + 3));
      check_eq("t1_cnt_le1", 32'(count <= 3'd1), 32'd1);
    end
    drain();
    check_eq("t1_empty", 32'(valid_out), 32'd0);

    // fill to full, overflow, then drain in order
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 4'(k), 4'(k + 3), 1'b0);
      if (k == 3) check_eq("t2_full", 32'(full), 32'd1);
      if (k == 3) check_eq("t2_no_ovf", 32'(overflow), 32'd0);
      if (k == 4) check_eq("t2_ovf", 32'(overflow), 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      check_eq("t2_drain_idx", 32'(idx_out), 32'(k));
      drain();
    end
    check_eq("t2_drained", 32'(count), 32'd0);
    check_eq("t2_ovf_sticky", 32'(overflow), 32'd1);

    // full with simultaneous push and pop
    do_reset();
    for (int k = 3; k < 7; k++) step(1'b1, 4'(k), 4'(k), 1'b0);
    step(1'b1, 4'd7, 4'd7, 1'b1);
    check_eq("t3_count", 32'(count), 32'd4);
    check_eq("t3_no_ovf", 32'(overflow), 32'd0);
    for (int k = 4; k < 8; k++) begin
      check_eq("t3_drain_idx", 32'(idx_out), 32'(k));
      drain();
    end

    // sequence wrap, first gap, later gap
    do_reset();
    step(1'b1, 4'd14, 4'd1, 1'b1);
    step(1'b1, 4'd15, 4'd2, 1'b1);
    step(1'b1, 4'd0,  4'd3, 1'b1);
    step(1'b1, 4'd1,  4'd4, 1'b1);
    check_eq("t4_wrap_ok", 32'(seq_err), 32'd0);
    step(1'b1, 4'd3, 4'd5, 1'b1);
`ifdef SEQ_CHECK_EN
    check_eq("t4_err", 32'(seq_err), 32'd1);
    check_eq("t4_err_idx", 32'(err_idx), 32'd3);
`else
    check_eq("t4_err_off", 32'(seq_err), 32'd0);
`endif
    step(1'b1, 4'd9, 4'd6, 1'b1);
`ifdef SEQ_CHECK_EN
    check_eq("t4_err_idx_frozen", 32'(err_idx), 32'd3);
`else
    check_eq("t4_err_idx_off", 32'(err_idx), 32'd0);
`endif
    drain();

    // reset with entries buffered
    do_reset();
    step(1'b1, 4'd10, 4'd1, 1'b0);
    step(1'b1, 4'd12, 4'd2, 1'b0);
    step(1'b1, 4'd13, 4'd3, 1'b0);
    check_eq("t5_count3", 32'(count), 32'd3);
    do_reset();
    check_eq("t5_count0", 32'(count), 32'd0);
    check_eq("t5_valid0", 32'(valid_out), 32'd0);
    check_eq("t5_seq0", 32'(seq_err), 32'd0);
    step(1'b1, 4'd8, 4'd9, 1'b0);
    check_eq("t5_idx8", 32'(idx_out), 32'd8);
    check_eq("t5_noerr", 32'(seq_err), 32'd0);

    // broken sequence 0,2: both delivered
    do_reset();
    step(1'b1, 4'd0, 4'd5, 1'b1);
    check_eq("t6_idx0", 32'(idx_out), 32'd0);
    step(1'b1, 4'd2, 4'd6, 1'b1);
    check_eq("t6_idx2", 32'(idx_out), 32'd2);
`ifndef SEQ_CHECK_EN
    check_eq("t6_seq_off", 32'(seq_err), 32'd0);
    check_eq("t6_erridx_off", 32'(err_idx), 32'd0);
`endif
    drain();

    // randomized traffic with occasional gaps and resets
    do_reset();
    last = 4'd15;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        nidx = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : last + 4'd1;
        if ($urandom_range(0, 2) != 0) begin
          step(1'b1, nidx, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
          last = nidx;
        end else begin
          step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
